// File: rtl/vga_pkg.sv
// ------------------------------------------------------------------
// vga_pkg : display geometry and shared terrain obstacle table. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package vga_pkg;

   localparam int HOR_PIXELS = 800;
   localparam int VER_PIXELS = 600;
   localparam int BORDER     = 6;

   typedef struct packed {
      logic [11:0] x1;
      logic [11:0] y1;
      logic [11:0] x2;
      logic [11:0] y2;
   } obst_t;

   localparam int N_OBST = 4;

   localparam logic [11:0] TERRAIN_0_X1 = 12'd62;
   localparam logic [11:0] TERRAIN_0_Y1 = 12'd10;
   localparam logic [11:0] TERRAIN_0_X2 = 12'd110;
   localparam logic [11:0] TERRAIN_0_Y2 = 12'd90;

   localparam logic [11:0] TERRAIN_1_X1 = 12'd300;
   localparam logic [11:0] TERRAIN_1_Y1 = 12'd200;
   localparam logic [11:0] TERRAIN_1_X2 = 12'd400;
   localparam logic [11:0] TERRAIN_1_Y2 = 12'd260;

   localparam logic [11:0] TERRAIN_2_X1 = 12'd500;
   localparam logic [11:0] TERRAIN_2_Y1 = 12'd50;
   localparam logic [11:0] TERRAIN_2_X2 = 12'd560;
   localparam logic [11:0] TERRAIN_2_Y2 = 12'd400;

   localparam logic [11:0] TERRAIN_3_X1 = 12'd100;
   localparam logic [11:0] TERRAIN_3_Y1 = 12'd450;
   localparam logic [11:0] TERRAIN_3_X2 = 12'd700;
   localparam logic [11:0] TERRAIN_3_Y2 = 12'd480;

   // Corners are [x1,x2) x [y1,y2); the background drawer renders the same table.
   localparam obst_t OBST_TABLE [N_OBST] = '{
      '{x1: TERRAIN_0_X1, y1: TERRAIN_0_Y1, x2: TERRAIN_0_X2, y2: TERRAIN_0_Y2},
      '{x1: TERRAIN_1_X1, y1: TERRAIN_1_Y1, x2: TERRAIN_1_X2, y2: TERRAIN_1_Y2},
      '{x1: TERRAIN_2_X1, y1: TERRAIN_2_Y1, x2: TERRAIN_2_X2, y2: TERRAIN_2_Y2},
      '{x1: TERRAIN_3_X1, y1: TERRAIN_3_Y1, x2: TERRAIN_3_X2, y2: TERRAIN_3_Y2}
   };

endpackage

`default_nettype wire

// File: rtl/obst_overlap.sv
// ------------------------------------------------------------------
// obst_overlap : combinational AABB test of a WxH rectangle vs one obstacle. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module obst_overlap
   import vga_pkg::*;
#(
   parameter int W = 32,
   parameter int H = 32
) (
   input  logic signed [13:0] cx_i,
   input  logic signed [13:0] cy_i,
   input  obst_t              obst_i,
   output logic               hit_o
);

   localparam logic signed [13:0] C_W = 14'(W);
   localparam logic signed [13:0] C_H = 14'(H);

   logic signed [13:0] w_x1;
   logic signed [13:0] w_y1;
   logic signed [13:0] w_x2;
   logic signed [13:0] w_y2;

   assign w_x1 = $signed({2'b00, obst_i.x1});
   assign w_y1 = $signed({2'b00, obst_i.y1});
   assign w_x2 = $signed({2'b00, obst_i.x2});
   assign w_y2 = $signed({2'b00, obst_i.y2});

   assign hit_o = (cx_i < w_x2) && ((cx_i + C_W) > w_x1) &&
                  (cy_i < w_y2) && ((cy_i + C_H) > w_y1);

endmodule

`default_nettype wire

// File: rtl/player_move_ctl.sv
// ------------------------------------------------------------------
// player_move_ctl : once-per-frame player move with border/obstacle rejection. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module player_move_ctl
   import vga_pkg::*;
#(
   parameter int STEP    = 4,
   parameter int RECT_W  = 32,
   parameter int RECT_H  = 32,
   parameter int START_X = 20,
   parameter int START_Y = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vblnk,
   input  logic        move_up,
   input  logic        move_down,
   input  logic        move_left,
   input  logic        move_right,
   output logic [11:0] xpos,
   output logic [11:0] ypos,
   output logic        blocked,
   output logic        busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LATCH  = 3'd1,
      S_BOUND  = 3'd2,
      S_CHECK  = 3'd3,
      S_COMMIT = 3'd4,
      S_REJECT = 3'd5
   } state_t;

   localparam int IDX_W = (N_OBST > 1) ? $clog2(N_OBST) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OBST - 1);

   localparam logic signed [13:0] C_STEP   = 14'(STEP);
   localparam logic signed [13:0] C_RW     = 14'(RECT_W);
   localparam logic signed [13:0] C_RH     = 14'(RECT_H);
   localparam logic signed [13:0] C_BORDER = 14'(BORDER);
   localparam logic signed [13:0] C_XLIM   = 14'(HOR_PIXELS - BORDER);
   localparam logic signed [13:0] C_YLIM   = 14'(VER_PIXELS - BORDER);

   state_t             state_q, state_d;
   logic               vblnk_q, vblnk_prev_q;
   logic [3:0]         btn_q, btn_d;
   logic signed [13:0] dx_q, dx_d, dy_q, dy_d;
   logic signed [13:0] cx_q, cx_d, cy_q, cy_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [11:0]        xpos_q, xpos_d, ypos_q, ypos_d;
   logic               blocked_q, blocked_d;

   logic               w_tick;
   logic signed [13:0] w_dx, w_dy, w_cx, w_cy;
   logic               w_oob;
   logic               w_hit;
   obst_t              w_obst;

   // Both edge-detector stages reset high so reset itself can never look like a rising edge.
   assign w_tick = vblnk_q & ~vblnk_prev_q;

   // btn_q = {up, down, left, right}; opposite buttons cancel.
   assign w_dx = (btn_q[0] ? C_STEP : 14'sd0) - (btn_q[1] ? C_STEP : 14'sd0);
   assign w_dy = (btn_q[2] ? C_STEP : 14'sd0) - (btn_q[3] ? C_STEP : 14'sd0);

   assign w_cx = $signed({2'b00, xpos_q}) + dx_q;
   assign w_cy = $signed({2'b00, ypos_q}) + dy_q;

   assign w_oob = (w_cx < C_BORDER) || (w_cy < C_BORDER) ||
                  ((w_cx + C_RW) > C_XLIM) || ((w_cy + C_RH) > C_YLIM);

   assign w_obst = OBST_TABLE[idx_q];

   obst_overlap #(
      .W (RECT_W),
      .H (RECT_H)
   ) u_overlap (
      .cx_i   (cx_q),
      .cy_i   (cy_q),
      .obst_i (w_obst),
      .hit_o  (w_hit)
   );

   always_comb begin
      state_d   = state_q;
      btn_d     = btn_q;
      dx_d      = dx_q;
      dy_d      = dy_q;
      cx_d      = cx_q;
      cy_d      = cy_q;
      idx_d     = idx_q;
      xpos_d    = xpos_q;
      ypos_d    = ypos_q;
      blocked_d = blocked_q;

      case (state_q)
         S_IDLE: begin
            if (w_tick) begin
               btn_d   = {move_up, move_down, move_left, move_right};
               state_d = S_LATCH;
            end
         end
         S_LATCH: begin
            dx_d = w_dx;
            dy_d = w_dy;
            if ((w_dx == 14'sd0) && (w_dy == 14'sd0)) begin
               blocked_d = 1'b0;
               state_d   = S_IDLE;
            end else begin
               state_d = S_BOUND;
            end
         end
         S_BOUND: begin
            cx_d  = w_cx;
            cy_d  = w_cy;
            idx_d = '0;
            state_d = w_oob ? S_REJECT : S_CHECK;
         end
         S_CHECK: begin
            if (w_hit) begin
               state_d = S_REJECT;
            end else if (idx_q == LAST_IDX) begin
               state_d = S_COMMIT;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_COMMIT: begin
            xpos_d    = cx_q[11:0];
            ypos_d    = cy_q[11:0];
            blocked_d = 1'b0;
            state_d   = S_IDLE;
         end
         S_REJECT: begin
            blocked_d = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         vblnk_q      <= 1'b1;
         vblnk_prev_q <= 1'b1;
         btn_q        <= '0;
         dx_q         <= '0;
         dy_q         <= '0;
         cx_q         <= '0;
         cy_q         <= '0;
         idx_q        <= '0;
         xpos_q       <= 12'(START_X);
         ypos_q       <= 12'(START_Y);
         blocked_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         vblnk_q      <= vblnk;
         vblnk_prev_q <= vblnk_q;
         btn_q        <= btn_d;
         dx_q         <= dx_d;
         dy_q         <= dy_d;
         cx_q         <= cx_d;
         cy_q         <= cy_d;
         idx_q        <= idx_d;
         xpos_q       <= xpos_d;
         ypos_q       <= ypos_d;
         blocked_q    <= blocked_d;
      end
   end

   assign xpos    = xpos_q;
   assign ypos    = ypos_q;
   assign blocked = blocked_q;
   assign busy    = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_player_move_ctl.sv
// ------------------------------------------------------------------
// tb_player_move_ctl : directed vector bench for player_move_ctl. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_player_move_ctl;
   import vga_pkg::*;

   localparam int LAT = N_OBST + 3;

   logic        clk;
   logic        rst;
   logic        vblnk;
   logic        move_up, move_down, move_left, move_right;
   logic [11:0] xpos, ypos;
   logic        blocked, busy;

   int n_chk = 0;
   int n_err = 0;

   // btn = {up, down, left, right}; elat = cycles from FSM leaving IDLE to position update, -1 = none
   typedef struct {
      logic [3:0] btn;
      int         ex;
      int         ey;
      int         eb;
      int         ebusy;
      int         elat;
   } vec_t;

   vec_t tv [20];

   player_move_ctl #(
      .STEP    (4),
      .RECT_W  (32),
      .RECT_H  (32),
      .START_X (20),
      .START_Y (20)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .vblnk      (vblnk),
      .move_up    (move_up),
      .move_down  (move_down),
      .move_left  (move_left),
      .move_right (move_right),
      .xpos       (xpos),
      .ypos       (ypos),
      .blocked    (blocked),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One vblank: vblnk high for 11 cycles then low; buttons released once latched.
   task automatic run_frame(input logic [3:0] btn, input bit inject,
                            output int busy_cnt, output int lat);
      logic [11:0] x0, y0;
      int first_busy, change_k;
      x0 = xpos;
      y0 = ypos;
      first_busy = -1;
      change_k   = -1;
      busy_cnt   = 0;
      {move_up, move_down, move_left, move_right} = btn;
      vblnk = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk);
         #1;
         if (busy) begin
            busy_cnt++;
            if (first_busy < 0) first_busy = k;
         end
         if ((change_k < 0) && ((xpos != x0) || (ypos != y0))) change_k = k;
         if (k == 2) {move_up, move_down, move_left, move_right} = 4'b0000;
         if (inject && (k == 4)) vblnk = 1'b0;
         if (inject && (k == 5)) begin
            vblnk     = 1'b1;
            move_down = 1'b1;
         end
         if (k == 12) begin
            vblnk     = 1'b0;
            move_down = 1'b0;
         end
      end
      lat = ((change_k >= 0) && (first_busy >= 0)) ? (change_k - first_busy) : -1;
   endtask

   initial begin
      int bc, lat;

      rst = 1'b1;
      vblnk = 1'b0;
      {move_up, move_down, move_left, move_right} = 4'b0000;

      tv[0]  = '{4'b0001, 24, 20, 0, LAT, LAT};   // right from start
      tv[1]  = '{4'b1100, 24, 20, 0, 1,   -1};    // up+down cancel
      tv[2]  = '{4'b0010, 20, 20, 0, LAT, LAT};
      tv[3]  = '{4'b0101, 24, 24, 0, LAT, LAT};   // diagonal right+down
      tv[4]  = '{4'b1000, 24, 20, 0, LAT, LAT};
      tv[5]  = '{4'b0001, 28, 20, 0, LAT, LAT};   // right edge now 2 px from obstacle 0
      tv[6]  = '{4'b0001, 28, 20, 1, 4,   -1};    // overlaps obstacle 0 at index 0
      tv[7]  = '{4'b0011, 28, 20, 0, 1,   -1};    // left+right cancel, clears blocked
      tv[8]  = '{4'b0010, 24, 20, 0, LAT, LAT};
      tv[9]  = '{4'b0010, 20, 20, 0, LAT, LAT};
      tv[10] = '{4'b0010, 16, 20, 0, LAT, LAT};
      tv[11] = '{4'b0010, 12, 20, 0, LAT, LAT};
      tv[12] = '{4'b0010, 8,  20, 0, LAT, LAT};
      tv[13] = '{4'b0010, 8,  20, 1, 3,   -1};    // cx=4 < border
      tv[14] = '{4'b1000, 8,  16, 0, LAT, LAT};
      tv[15] = '{4'b1000, 8,  12, 0, LAT, LAT};
      tv[16] = '{4'b1000, 8,  8,  0, LAT, LAT};
      tv[17] = '{4'b1000, 8,  8,  1, 3,   -1};    // cy=4 < border
      tv[18] = '{4'b0000, 8,  8,  0, 1,   -1};
      tv[19] = '{4'b0110, 8,  8,  1, 3,   -1};    // diagonal: legal down axis must not slide

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("reset_xpos", int'(xpos), 20);
      chk("reset_ypos", int'(ypos), 20);
      chk("reset_blocked", int'(blocked), 0);
      chk("reset_busy", int'(busy), 0);
      repeat (3) @(posedge clk);
      #1;

      for (int i = 0; i < 20; i++) begin
         run_frame(tv[i].btn, 1'b0, bc, lat);
         chk($sformatf("v%0d_xpos", i), int'(xpos), tv[i].ex);
         chk($sformatf("v%0d_ypos", i), int'(ypos), tv[i].ey);
         chk($sformatf("v%0d_blocked", i), int'(blocked), tv[i].eb);
         chk($sformatf("v%0d_busy_cycles", i), bc, tv[i].ebusy);
         chk($sformatf("v%0d_latency", i), lat, tv[i].elat);
      end

      // Reset during CHECK: abort with no partial commit.
      {move_up, move_down, move_left, move_right} = 4'b0001;
      vblnk = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         if (k == 2) {move_up, move_down, move_left, move_right} = 4'b0000;
      end
      chk("midcheck_busy", int'(busy), 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_abort_xpos", int'(xpos), 20);
      chk("rst_abort_ypos", int'(ypos), 20);
      chk("rst_abort_busy", int'(busy), 0);
      chk("rst_abort_blocked", int'(blocked), 0);
      rst = 1'b0;
      bc = 0;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (busy) bc++;
      end
      chk("no_tick_after_rst", bc, 0);
      chk("no_tick_after_rst_xpos", int'(xpos), 20);
      vblnk = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      run_frame(4'b0001, 1'b0, bc, lat);
      chk("post_rst_xpos", int'(xpos), 24);
      chk("post_rst_ypos", int'(ypos), 20);
      chk("post_rst_latency", lat, LAT);

      run_frame(4'b0001, 1'b1, bc, lat);
      chk("inject_xpos", int'(xpos), 28);
      chk("inject_ypos", int'(ypos), 20);
      chk("inject_busy_cycles", bc, LAT);
      chk("inject_blocked", int'(blocked), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
